// File: rtl/mdu_ctrl_if.sv
// Handshake/result bundle between the E-stage pipeline and the multiply/divide controller.
// master = pipeline side, slave = mdu_ctrl.
interface mdu_ctrl_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hilo_sel;
    logic        busy;
    logic [31:0] mdm_rd;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdu_op, src_a, src_b, hilo_sel,
        input  busy, mdm_rd, hi, lo
    );

    modport slave (
        input  start, mdu_op, src_a, src_b, hilo_sel,
        output busy, mdm_rd, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: fixed-latency MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with busy for stall logic.
// Optional feature macro MDU_MADD_EN enables MADD (op 7) / MSUB (op 8) 64-bit accumulate.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_ctrl_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [3:0] OP_MULT   = 4'd1;
    localparam logic [3:0] OP_MULTU  = 4'd2;
    localparam logic [3:0] OP_DIV    = 4'd3;
    localparam logic [3:0] OP_DIVU   = 4'd4;
    localparam logic [3:0] OP_MTHI   = 4'd5;
    localparam logic [3:0] OP_MTLO   = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD   = 4'd7;
    localparam logic [3:0] OP_MSUB   = 4'd8;
`endif
    localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [3:0]  n_last;
    logic        accept, is_div, op_sgn;
    logic [63:0] res_nxt;
    logic        wr_nxt;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;
    logic [31:0] hi_reg, lo_reg;
    logic        commit;

    // Full 64-bit product; operands are extended to 64 bits so the signed
    // multiply yields the exact two's-complement result.
    function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
        logic signed [63:0] sa, sb, prod;
        sa   = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        sb   = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        prod = sa * sb;
        return prod;
    endfunction

    // Returns {remainder, quotient}. Signed division runs on magnitudes so the
    // quotient truncates toward zero and the remainder takes the dividend's sign.
    function automatic logic [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
        logic [31:0] ua, ub, q, r;
        logic [63:0] res;
        ua = a;
        ub = b;
        q  = 32'd0;
        r  = 32'd0;
        if (b == 32'd0) begin
            res = 64'd0;
        end else if (!sgn) begin
            res = {a % b, a / b};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = {32'd0, 32'h8000_0000};
        end else begin
            ua  = a[31] ? (~a + 32'd1) : a;
            ub  = b[31] ? (~b + 32'd1) : b;
            q   = ua / ub;
            r   = ua % ub;
            res = {a[31] ? (~r + 32'd1) : r, (a[31] ^ b[31]) ? (~q + 32'd1) : q};
        end
        return res;
    endfunction

    // Decode: only a start seen in IDLE is accepted; everything else is dropped.
    always_comb begin
        accept = 1'b0;
        is_div = 1'b0;
        op_sgn = 1'b0;
        n_last = MULT_LAST;
        if (state == IDLE && bus.start) begin
            case (bus.mdu_op)
                OP_MULT:  begin accept = 1'b1; op_sgn = 1'b1; end
                OP_MULTU: begin accept = 1'b1; end
                OP_DIV:   begin accept = 1'b1; op_sgn = 1'b1; is_div = 1'b1; n_last = DIV_LAST; end
                OP_DIVU:  begin accept = 1'b1; is_div = 1'b1; n_last = DIV_LAST; end
`ifdef MDU_MADD_EN
                OP_MADD,
                OP_MSUB:  begin accept = 1'b1; op_sgn = 1'b1; end
`endif
                default:  ;
            endcase
        end
    end

    always_comb begin
        res_nxt = is_div ? div_full(bus.src_a, bus.src_b, op_sgn)
                         : mul_full(bus.src_a, bus.src_b, op_sgn);
        wr_nxt  = !(is_div && bus.src_b == 32'd0);
`ifdef MDU_MADD_EN
        if (bus.mdu_op == OP_MADD)
            res_nxt = {hi_reg, lo_reg} + mul_full(bus.src_a, bus.src_b, 1'b1);
        else if (bus.mdu_op == OP_MSUB)
            res_nxt = {hi_reg, lo_reg} - mul_full(bus.src_a, bus.src_b, 1'b1);
`endif
    end

    // Shadow result: captured at the start edge, committed when the count expires.
    always_ff @(posedge clk) begin
        if (accept) begin
            res_hi <= res_nxt[63:32];
            res_lo <= res_nxt[31:0];
            res_wr <= wr_nxt;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // FSM next-state
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    cnt_nxt   = n_last;
                end
            end
            RUN: begin
                if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
                else             state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign commit = (state == RUN) && (cnt == 4'd0) && res_wr;

    // HI/LO: commit only happens in RUN and MT* only in IDLE, so they never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else if (commit) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
        end else if (state == IDLE && bus.start) begin
            if (bus.mdu_op == OP_MTHI) hi_reg <= bus.src_a;
            if (bus.mdu_op == OP_MTLO) lo_reg <= bus.src_a;
        end
    end

    // FSM outputs
    always_comb begin
        bus.busy   = (state == RUN);
        bus.mdm_rd = bus.hilo_sel ? hi_reg : lo_reg;
        bus.hi     = hi_reg;
        bus.lo     = lo_reg;
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, MULT/DIV results, MT*, ignored starts, reset abort, MADD/MSUB.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Present one start for a single edge; returns 1ns after that edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.src_a  = a;
        bus.src_b  = b;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.mdu_op = 4'd0;
    endtask

    // Counts cycles busy stays high from now on (bounded).
    task automatic busy_len(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %h exp 0", bus.busy); end
        tests++; if (bus.hi !== 32'd0) begin fails++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
        tests++; if (bus.lo !== 32'd0) begin fails++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
        tests++; if (bus.mdm_rd !== 32'd0) begin fails++; $display("FAIL reset_mdm_rd got %h exp 0", bus.mdm_rd); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult;
        int n;
        issue(4'd1, 32'hFFFF_FFFF, 32'd2);
        busy_len(n);
        tests++; if (n != 5) begin fails++; $display("FAIL mult_busy_len got %0d exp 5", n); end
        tests++; if (bus.hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
        tests++; if (bus.lo !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mult_lo got %h exp fffffffe", bus.lo); end
        bus.hilo_sel = 1'b1; #1;
        tests++; if (bus.mdm_rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_mdm_hi got %h exp ffffffff", bus.mdm_rd); end
        bus.hilo_sel = 1'b0; #1;
        tests++; if (bus.mdm_rd !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mult_mdm_lo got %h exp fffffffe", bus.mdm_rd); end
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        busy_len(n);
        tests++; if (n != 5) begin fails++; $display("FAIL multu_busy_len got %0d exp 5", n); end
        tests++; if (bus.hi !== 32'h0000_0001) begin fails++; $display("FAIL multu_hi got %h exp 00000001", bus.hi); end
        tests++; if (bus.lo !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_lo got %h exp fffffffe", bus.lo); end
    endtask

    task automatic test_div;
        int n;
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        busy_len(n);
        tests++; if (n != 10) begin fails++; $display("FAIL div_busy_len got %0d exp 10", n); end
        tests++; if (bus.lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_lo got %h exp fffffffd", bus.lo); end
        tests++; if (bus.hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_hi got %h exp ffffffff", bus.hi); end
        issue(4'd4, 32'd7, 32'd0);
        busy_len(n);
        tests++; if (n != 10) begin fails++; $display("FAIL divz_busy_len got %0d exp 10", n); end
        tests++; if (bus.lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL divz_lo got %h exp fffffffd", bus.lo); end
        tests++; if (bus.hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divz_hi got %h exp ffffffff", bus.hi); end
        issue(4'd4, 32'd100, 32'd7);
        busy_len(n);
        tests++; if (bus.lo !== 32'd14) begin fails++; $display("FAIL divu_lo got %h exp 0000000e", bus.lo); end
        tests++; if (bus.hi !== 32'd2) begin fails++; $display("FAIL divu_hi got %h exp 00000002", bus.hi); end
        issue(4'd3, 32'd7, 32'hFFFF_FFFE);
        busy_len(n);
        tests++; if (bus.lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_negb_lo got %h exp fffffffd", bus.lo); end
        tests++; if (bus.hi !== 32'd1) begin fails++; $display("FAIL div_negb_hi got %h exp 00000001", bus.hi); end
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_len(n);
        tests++; if (bus.lo !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_lo got %h exp 80000000", bus.lo); end
        tests++; if (bus.hi !== 32'd0) begin fails++; $display("FAIL div_ovf_hi got %h exp 00000000", bus.hi); end
    endtask

    task automatic test_mt_nop;
        issue(4'd5, 32'h0000_5555, 32'd0);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mthi_busy got %h exp 0", bus.busy); end
        tests++; if (bus.hi !== 32'h0000_5555) begin fails++; $display("FAIL mthi_hi got %h exp 00005555", bus.hi); end
        issue(4'd6, 32'h0000_AAAA, 32'd0);
        tests++; if (bus.lo !== 32'h0000_AAAA) begin fails++; $display("FAIL mtlo_lo got %h exp 0000aaaa", bus.lo); end
        issue(4'd0, 32'h1111_1111, 32'd3);
        issue(4'd9, 32'h2222_2222, 32'd3);
        issue(4'd15, 32'h3333_3333, 32'd3);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL undef_busy got %h exp 0", bus.busy); end
        tests++; if (bus.hi !== 32'h0000_5555) begin fails++; $display("FAIL undef_hi got %h exp 00005555", bus.hi); end
        tests++; if (bus.lo !== 32'h0000_AAAA) begin fails++; $display("FAIL undef_lo got %h exp 0000aaaa", bus.lo); end
    endtask

    task automatic test_back_to_back;
        int n;
        issue(4'd6, 32'h0000_1234, 32'd0);
        tests++; if (bus.lo !== 32'h0000_1234) begin fails++; $display("FAIL b2b_mtlo got %h exp 00001234", bus.lo); end
        issue(4'd1, 32'd3, 32'd4);
        @(posedge clk); #1;
        issue(4'd1, 32'd5, 32'd6);
        issue(4'd5, 32'h0000_DEAD, 32'd0);
        tests++; if (bus.hi !== 32'h0000_5555) begin fails++; $display("FAIL b2b_mthi_ignored got %h exp 00005555", bus.hi); end
        busy_len(n);
        tests++; if (n != 2) begin fails++; $display("FAIL b2b_busy_tail got %0d exp 2", n); end
        bus.hilo_sel = 1'b0; #1;
        tests++; if (bus.mdm_rd !== 32'd12) begin fails++; $display("FAIL b2b_mdm_lo got %h exp 0000000c", bus.mdm_rd); end
        tests++; if (bus.hi !== 32'd0) begin fails++; $display("FAIL b2b_hi got %h exp 00000000", bus.hi); end
        @(posedge clk); #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_second_ignored got %h exp 0", bus.busy); end
    endtask

    task automatic test_madd;
        int n;
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0);
        issue(4'd7, 32'd1, 32'd1);
        busy_len(n);
`ifdef MDU_MADD_EN
        tests++; if (n != 5) begin fails++; $display("FAIL madd_busy_len got %0d exp 5", n); end
        tests++; if (bus.hi !== 32'd1) begin fails++; $display("FAIL madd_hi got %h exp 00000001", bus.hi); end
        tests++; if (bus.lo !== 32'd0) begin fails++; $display("FAIL madd_lo got %h exp 00000000", bus.lo); end
        issue(4'd8, 32'd2, 32'd3);
        busy_len(n);
        tests++; if (n != 5) begin fails++; $display("FAIL msub_busy_len got %0d exp 5", n); end
        tests++; if (bus.hi !== 32'd0) begin fails++; $display("FAIL msub_hi got %h exp 00000000", bus.hi); end
        tests++; if (bus.lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL msub_lo got %h exp fffffffa", bus.lo); end
`else
        tests++; if (n != 0) begin fails++; $display("FAIL madd_off_busy got %0d exp 0", n); end
        tests++; if (bus.hi !== 32'd0) begin fails++; $display("FAIL madd_off_hi got %h exp 00000000", bus.hi); end
        tests++; if (bus.lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL madd_off_lo got %h exp ffffffff", bus.lo); end
        issue(4'd8, 32'd2, 32'd3);
        busy_len(n);
        tests++; if (n != 0) begin fails++; $display("FAIL msub_off_busy got %0d exp 0", n); end
        tests++; if (bus.lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL msub_off_lo got %h exp ffffffff", bus.lo); end
`endif
    endtask

    task automatic test_reset_abort;
        issue(4'd6, 32'h0000_0077, 32'd0);
        issue(4'd4, 32'd100, 32'd7);
        repeat (2) begin @(posedge clk); #1; end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before got %h exp 1", bus.busy); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %h exp 0", bus.busy); end
        tests++; if (bus.lo !== 32'd0) begin fails++; $display("FAIL abort_lo got %h exp 0", bus.lo); end
        tests++; if (bus.hi !== 32'd0) begin fails++; $display("FAIL abort_hi got %h exp 0", bus.hi); end
        reset = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_idle got %h exp 0", bus.busy); end
        tests++; if (bus.lo !== 32'd0) begin fails++; $display("FAIL abort_no_commit_lo got %h exp 0", bus.lo); end
        tests++; if (bus.hi !== 32'd0) begin fails++; $display("FAIL abort_no_commit_hi got %h exp 0", bus.hi); end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.mdu_op   = 4'd0;
        bus.src_a    = 32'd0;
        bus.src_b    = 32'd0;
        bus.hilo_sel = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mt_nop();
        test_back_to_back();
        test_madd();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
